// File: rtl/hall_pkg.sv
// hall_pkg: sector/state types and hall-code decode shared by the hall speed decoder.
package hall_pkg;
  localparam int HALL_SECTORS = 6;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, UNKNOWN = 3'd7} sector_t;
  typedef enum logic [1:0] {UNLOCKED, TRACKING, FAULT} state_t;
  function automatic sector_t hall_to_sector(input logic [2:0] code);
    case (code)
      3'b100: return S0;
      3'b110: return S1;
      3'b010: return S2;
      3'b011: return S3;
      3'b001: return S4;
      3'b101: return S5;
      default: return UNKNOWN;
    endcase
  endfunction
endpackage

// File: rtl/hall_input_filter.sv
// hall_input_filter: 2-FF synchronizer for {U,V,W}; HALL_DEGLITCH_EN adds a per-bit stability filter.
module hall_input_filter #(
  parameter int FILTER_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw,
  output logic [2:0] h
);
  logic [2:0] s1, s2;
  if (FILTER_CYCLES < 2) begin : g_bad
    $error("FILTER_CYCLES must be at least 2");
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) {s2, s1} <= '0;
    else {s2, s1} <= {s1, raw};
`ifdef HALL_DEGLITCH_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  for (genvar i = 0; i < 3; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic hb;
    // The cycle a new level lands in s2 is the first of its FILTER_CYCLES stable cycles.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        hb <= 1'b0;
      end else if (s2[i] == hb) cnt <= '0;
      else if (cnt == CW'(FILTER_CYCLES - 2)) begin
        cnt <= '0;
        hb <= s2[i];
      end else cnt <= cnt + 1'b1;
    assign h[i] = hb;
  end
`else
  assign h = s2;
`endif
endmodule

// File: rtl/hall_speed_decoder.sv
// hall_speed_decoder: hall sector/direction tracking, per-period signed step count and commutation period.
// Define HALL_DEGLITCH_EN to enable the input stability filter.
module hall_speed_decoder
  import hall_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int PERIOD_WIDTH   = 20,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_CYCLES  = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trigger,
  input  logic [2:0]                    sensor_hall_uvw,
  output logic signed [DATA_WIDTH-1:0]  speed_source_data,
  output logic [PERIOD_WIDTH-1:0]       period_source_data,
  output logic                          speed_source_valid,
  output logic [2:0]                    hall_sector,
  output logic                          hall_direction,
  output logic                          status_hall_fault_n,
  output logic                          hall_jump
);
  localparam logic [PERIOD_WIDTH-1:0] TMO = PERIOD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << PERIOD_WIDTH)) begin : g_bad
    $error("TIMEOUT_CYCLES must fit in PERIOD_WIDTH");
  end
  logic [2:0] h, nxt, prv;
  state_t state, state_n;
  sector_t sector, sec_in;
  logic moved, fwd, rev, step, jump, entry, same_dir, restart;
  logic signed [DATA_WIDTH-1:0] acc, acc_sum, step_val;
  logic [PERIOD_WIDTH-1:0] cnt, period_last;
  hall_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clk(clk), .reset(reset), .raw(sensor_hall_uvw), .h(h)
  );
  assign sec_in = hall_to_sector(h);
  assign nxt = 3'(sector) == 3'(HALL_SECTORS - 1) ? 3'd0 : 3'(sector) + 3'd1;
  assign prv = sector == S0 ? 3'(HALL_SECTORS - 1) : 3'(sector) - 3'd1;
  assign moved = state == TRACKING && sec_in != UNKNOWN && sec_in != sector;
  assign fwd = moved && 3'(sec_in) == nxt;
  assign rev = moved && 3'(sec_in) == prv;
  assign step = fwd || rev;
  assign jump = moved && !step;
  assign entry = state != TRACKING && sec_in != UNKNOWN;
  assign same_dir = step && rev == hall_direction;
  assign restart = entry || jump || (step && !same_dir);
  assign step_val = fwd ? DATA_WIDTH'(1) : rev ? '1 : '0;
  assign acc_sum = ((fwd && acc == ACC_MAX) || (rev && acc == -ACC_MAX)) ? acc : acc + step_val;
  assign hall_sector = sector;
  assign status_hall_fault_n = state != FAULT;
  always_comb begin
    state_n = state;
    state_n = sec_in != UNKNOWN ? TRACKING : state == TRACKING ? FAULT : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= UNLOCKED;
      sector <= UNKNOWN;
      hall_direction <= 1'b0;
      hall_jump <= 1'b0;
      acc <= '0;
      cnt <= TMO;
      period_last <= TMO;
      speed_source_data <= '0;
      period_source_data <= TMO;
      speed_source_valid <= 1'b0;
    end else begin
      state <= state_n;
      // Outside TRACKING the old sector is UNKNOWN, so the decode is always the new sector.
      sector <= sec_in;
      hall_direction <= step ? rev : hall_direction;
      hall_jump <= jump;
      cnt <= (step || restart) ? PERIOD_WIDTH'(1) : cnt == TMO ? TMO : cnt + 1'b1;
      period_last <= same_dir ? cnt : (restart || cnt == TMO) ? TMO : period_last;
      // A step coincident with trigger opens the new window.
      acc <= trigger ? step_val : acc_sum;
      speed_source_valid <= trigger;
      if (trigger) begin
        speed_source_data <= acc;
        period_source_data <= period_last;
      end
    end
endmodule

// File: tb/tb_hall_speed_decoder.sv
// tb_hall_speed_decoder: directed scenarios plus randomized hall walks checked against a timestamp-based model.
module tb_hall_speed_decoder;
  localparam int DW = 16, PW = 20, TO = 2000, MAXV = 2 ** (DW - 1) - 1;
  logic clk = 0, reset = 1, trigger = 0;
  logic [2:0] sensor_hall_uvw = 3'b000;
  logic signed [DW-1:0] speed_source_data;
  logic [PW-1:0] period_source_data;
  logic speed_source_valid, hall_direction, status_hall_fault_n, hall_jump;
  logic [2:0] hall_sector;
  int errors = 0, checks = 0;
  logic [2:0] codes [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  int m_mode, m_sec, m_dir, m_acc, m_period, e_data, e_period, e_valid, e_jump;
  longint n, t0;
  logic [2:0] h1, h2;
  always #5 clk = ~clk;
  hall_speed_decoder #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PW), .TIMEOUT_CYCLES(TO), .FILTER_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .sensor_hall_uvw(sensor_hall_uvw),
    .speed_source_data(speed_source_data), .period_source_data(period_source_data),
    .speed_source_valid(speed_source_valid), .hall_sector(hall_sector),
    .hall_direction(hall_direction), .status_hall_fault_n(status_hall_fault_n), .hall_jump(hall_jump)
  );
  function automatic int sec_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (codes[i] == c) return i;
    return -1;
  endfunction
  // m_mode: 0 unlocked, 1 tracking, 2 fault; t0 is the edge the period reference restarted.
  function automatic void model_reset();
    m_mode = 0; m_sec = 7; m_dir = 0; m_acc = 0; m_period = TO;
    e_data = 0; e_period = TO; e_valid = 0; e_jump = 0;
    n = 0; t0 = -10 * TO; h1 = 0; h2 = 0;
  endfunction
  function automatic void model_edge(input logic [2:0] hv, input logic trg);
    int s, st, d, pl;
    n++;
    s = sec_of(hv);
    st = 0;
    pl = (n - t0 > TO) ? TO : m_period;
    e_jump = 0;
    if (s < 0) begin
      if (m_mode == 1) m_mode = 2;
      m_sec = 7;
    end else if (m_mode != 1) begin
      m_mode = 1; m_sec = s; m_period = TO; t0 = n;
    end else if (s != m_sec) begin
      d = (s - m_sec + 6) % 6;
      if (d == 1 || d == 5) begin
        st = d == 1 ? 1 : -1;
        m_period = (int'(d == 5) == m_dir) ? ((n - t0 > TO) ? TO : int'(n - t0)) : TO;
        m_dir = int'(d == 5);
      end else begin
        e_jump = 1; m_period = TO;
      end
      t0 = n;
      m_sec = s;
    end
    e_valid = trg;
    if (trg) begin
      e_data = m_acc; e_period = pl; m_acc = st;
    end else m_acc = (m_acc + st > MAXV) ? MAXV : (m_acc + st < -MAXV) ? -MAXV : m_acc + st;
  endfunction
  task automatic cyc(input logic [2:0] s, input logic t);
    sensor_hall_uvw = s; trigger = t;
    @(posedge clk); #1;
    model_edge(h2, t);
    h2 = h1; h1 = s;
  endtask
  task automatic hold(input logic [2:0] s, input int k);
    repeat (k) cyc(s, 0);
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (speed_source_data !== 0) begin errors++; $display("FAIL reset_data: got %0d want 0", speed_source_data); end
    if (period_source_data !== TO) begin errors++; $display("FAIL reset_period: got %0d want %0d", period_source_data, TO); end
    if (speed_source_valid !== 0) begin errors++; $display("FAIL reset_valid: got %b want 0", speed_source_valid); end
    if (hall_sector !== 7) begin errors++; $display("FAIL reset_sector: got %0d want 7", hall_sector); end
    if (hall_direction !== 0) begin errors++; $display("FAIL reset_dir: got %b want 0", hall_direction); end
    if (status_hall_fault_n !== 1) begin errors++; $display("FAIL reset_fault_n: got %b want 1", status_hall_fault_n); end
    if (hall_jump !== 0) begin errors++; $display("FAIL reset_jump: got %b want 0", hall_jump); end
    reset = 0;
    model_reset();
  endtask
`ifdef HALL_DEGLITCH_EN
  task automatic test_deglitch();
    hold(3'b100, 30);
    checks++;
    if (hall_sector !== 0) begin errors++; $display("FAIL dg_lock: sector %0d want 0", hall_sector); end
    hold(3'b110, 10);
    for (int i = 0; i < 40; i++) begin
      cyc(3'b100, 0);
      checks++;
      if (hall_sector !== 0) begin errors++; $display("FAIL dg_glitch: cycle %0d sector %0d want 0", i, hall_sector); end
    end
    for (int i = 1; i <= 17; i++) begin
      cyc(3'b110, 0);
      checks++;
      if (hall_sector !== (i < 17 ? 3'd0 : 3'd1))
        begin errors++; $display("FAIL dg_latency: cycle %0d sector %0d want %0d", i, hall_sector, i < 17 ? 0 : 1); end
    end
  endtask
`else
  task automatic test_forward();
    hold(codes[0], 10);
    checks += 2;
    if (hall_sector !== 0) begin errors++; $display("FAIL fwd_lock: sector %0d want 0", hall_sector); end
    if (status_hall_fault_n !== 1) begin errors++; $display("FAIL fwd_fault_n: got %b want 1", status_hall_fault_n); end
    for (int i = 1; i < 6; i++) hold(codes[i], 200);
    cyc(codes[5], 1);
    checks += 5;
    if (speed_source_valid !== 1) begin errors++; $display("FAIL fwd_valid: got %b want 1", speed_source_valid); end
    if (speed_source_data !== 5) begin errors++; $display("FAIL fwd_data: got %0d want 5", speed_source_data); end
    if (period_source_data !== 200) begin errors++; $display("FAIL fwd_period: got %0d want 200", period_source_data); end
    if (hall_sector !== 5) begin errors++; $display("FAIL fwd_sector: got %0d want 5", hall_sector); end
    if (hall_direction !== 0) begin errors++; $display("FAIL fwd_dir: got %b want 0", hall_direction); end
    cyc(codes[5], 0);
    checks++;
    if (speed_source_valid !== 0) begin errors++; $display("FAIL fwd_valid_pulse: got %b want 0", speed_source_valid); end
  endtask
  task automatic test_reverse();
    for (int i = 4; i >= 0; i--) hold(codes[i], 300);
    cyc(codes[0], 1);
    checks += 3;
    if (speed_source_data !== -5) begin errors++; $display("FAIL rev_data: got %0d want -5", speed_source_data); end
    if (period_source_data !== 300) begin errors++; $display("FAIL rev_period: got %0d want 300", period_source_data); end
    if (hall_direction !== 1) begin errors++; $display("FAIL rev_dir: got %b want 1", hall_direction); end
    hold(codes[1], 50);
    cyc(codes[1], 1);
    checks += 3;
    if (speed_source_data !== 1) begin errors++; $display("FAIL rev_back_data: got %0d want 1", speed_source_data); end
    if (period_source_data !== TO) begin errors++; $display("FAIL rev_back_period: got %0d want %0d", period_source_data, TO); end
    if (hall_direction !== 0) begin errors++; $display("FAIL rev_back_dir: got %b want 0", hall_direction); end
  endtask
  task automatic test_fault();
    hold(3'b000, 10);
    checks += 2;
    if (status_hall_fault_n !== 0) begin errors++; $display("FAIL flt_fault_n: got %b want 0", status_hall_fault_n); end
    if (hall_sector !== 7) begin errors++; $display("FAIL flt_sector: got %0d want 7", hall_sector); end
    hold(3'b010, 10);
    checks += 2;
    if (status_hall_fault_n !== 1) begin errors++; $display("FAIL flt_recover: got %b want 1", status_hall_fault_n); end
    if (hall_sector !== 2) begin errors++; $display("FAIL flt_resector: got %0d want 2", hall_sector); end
    cyc(3'b010, 1);
    checks++;
    if (speed_source_data !== 0) begin errors++; $display("FAIL flt_data: got %0d want 0", speed_source_data); end
  endtask
  task automatic test_jump();
    int pulses = 0;
    hold(3'b100, 20);
    cyc(3'b100, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(3'b010, 0);
      pulses += int'(hall_jump);
    end
    checks += 2;
    if (pulses !== 1) begin errors++; $display("FAIL jump_pulses: got %0d want 1", pulses); end
    if (hall_sector !== 2) begin errors++; $display("FAIL jump_sector: got %0d want 2", hall_sector); end
    hold(3'b010, TO + 10);
    cyc(3'b010, 1);
    checks += 2;
    if (speed_source_data !== 0) begin errors++; $display("FAIL jump_data: got %0d want 0", speed_source_data); end
    if (period_source_data !== TO) begin errors++; $display("FAIL jump_stall: got %0d want %0d", period_source_data, TO); end
  endtask
  task automatic test_coincident();
    cyc(3'b011, 0);
    cyc(3'b011, 0);
    cyc(3'b011, 1);
    checks += 2;
    if (speed_source_data !== 0) begin errors++; $display("FAIL coin_data: got %0d want 0", speed_source_data); end
    if (hall_sector !== 3) begin errors++; $display("FAIL coin_sector: got %0d want 3", hall_sector); end
    hold(3'b011, 5);
    cyc(3'b011, 1);
    checks++;
    if (speed_source_data !== 1) begin errors++; $display("FAIL coin_next: got %0d want 1", speed_source_data); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      cyc(codes[(3 + i / 3) % 6], 1);
      checks += 3;
      if (speed_source_valid !== 1) begin errors++; $display("FAIL b2b_valid: cycle %0d got %b want 1", i, speed_source_valid); end
      if (speed_source_data !== e_data) begin errors++; $display("FAIL b2b_data: cycle %0d got %0d want %0d", i, speed_source_data, e_data); end
      if (period_source_data !== e_period) begin errors++; $display("FAIL b2b_period: cycle %0d got %0d want %0d", i, period_source_data, e_period); end
    end
  endtask
  task automatic test_random();
    logic [2:0] nc;
    int ci, r, len;
    for (int seg = 0; seg < 300; seg++) begin
      ci = sec_of(sensor_hall_uvw);
      r = $urandom_range(99);
      if (ci < 0 || r < 8) nc = codes[$urandom_range(5)];
      else if (r < 14) nc = $urandom_range(1) ? 3'b000 : 3'b111;
      else if (r < 60) nc = codes[(ci + 1) % 6];
      else if (r < 90) nc = codes[(ci + 5) % 6];
      else nc = codes[ci];
      len = ($urandom_range(49) == 0) ? TO + 50 : $urandom_range(1, 60);
      for (int k = 0; k < len; k++) begin
        cyc(nc, $urandom_range(15) == 0);
        checks += 7;
        if (speed_source_valid !== e_valid[0]) begin errors++; $display("FAIL rnd_valid: seg %0d got %b want %0d", seg, speed_source_valid, e_valid); end
        if (speed_source_data !== e_data) begin errors++; $display("FAIL rnd_data: seg %0d got %0d want %0d", seg, speed_source_data, e_data); end
        if (period_source_data !== e_period) begin errors++; $display("FAIL rnd_period: seg %0d got %0d want %0d", seg, period_source_data, e_period); end
        if (hall_sector !== 3'(m_sec)) begin errors++; $display("FAIL rnd_sector: seg %0d got %0d want %0d", seg, hall_sector, m_sec); end
        if (hall_direction !== m_dir[0]) begin errors++; $display("FAIL rnd_dir: seg %0d got %b want %0d", seg, hall_direction, m_dir); end
        if (status_hall_fault_n !== (m_mode != 2)) begin errors++; $display("FAIL rnd_fault_n: seg %0d got %b want %0d", seg, status_hall_fault_n, m_mode != 2); end
        if (hall_jump !== e_jump[0]) begin errors++; $display("FAIL rnd_jump: seg %0d got %b want %0d", seg, hall_jump, e_jump); end
      end
    end
  endtask
  task automatic test_reset_mid();
    hold(3'b100, 10);
    hold(3'b110, 10);
    sensor_hall_uvw = 3'b010; trigger = 1;
    #2 reset = 1;
    #1;
    checks += 5;
    if (hall_sector !== 7) begin errors++; $display("FAIL mid_sector: got %0d want 7", hall_sector); end
    if (hall_direction !== 0) begin errors++; $display("FAIL mid_dir: got %b want 0", hall_direction); end
    if (speed_source_data !== 0) begin errors++; $display("FAIL mid_data: got %0d want 0", speed_source_data); end
    if (period_source_data !== TO) begin errors++; $display("FAIL mid_period: got %0d want %0d", period_source_data, TO); end
    if (status_hall_fault_n !== 1) begin errors++; $display("FAIL mid_fault_n: got %b want 1", status_hall_fault_n); end
    @(posedge clk); #1;
    checks++;
    if (speed_source_valid !== 0) begin errors++; $display("FAIL mid_valid_dropped: got %b want 0", speed_source_valid); end
    trigger = 0; reset = 0;
    model_reset();
    hold(3'b110, 10);
    checks++;
    if (hall_sector !== 1) begin errors++; $display("FAIL mid_relock: got %0d want 1", hall_sector); end
  endtask
`endif
  initial begin
    model_reset();
    test_reset();
`ifdef HALL_DEGLITCH_EN
    test_deglitch();
`else
    test_forward();
    test_reverse();
    test_fault();
    test_jump();
    test_coincident();
    test_back_to_back();
    test_random();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
